// File: rtl/xunit_f.sv
// SHA-256 compression-round unit: loads a..h after a programmable start delay,
// then applies one round per clock using a registered W+K sum.
module xunit_f #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  input  logic [DATA_W-1:0] in8,
  input  logic [DATA_W-1:0] in9,
  input  logic [7:0]        delay0,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [DATA_W-1:0] out4,
  output logic [DATA_W-1:0] out5,
  output logic [DATA_W-1:0] out6,
  output logic [DATA_W-1:0] out7
);

  localparam int unsigned NUM_WORDS = 8;
  localparam int unsigned CNT_W     = 8;

  // IDLE: never loaded; ARMED: counting down delay; FILL: loaded, first wk pending
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FILL  = 2'd2,
    ST_ROUND = 2'd3
  } st_e;

  st_e               st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] wk_q, wk_d;
  logic [DATA_W-1:0] wv_q [NUM_WORDS];
  logic [DATA_W-1:0] wv_d [NUM_WORDS];

  logic [DATA_W-1:0] a, b, c, d, e, f, g, h;
  logic [DATA_W-1:0] s0, s1, ch, maj, t1, t2;

  assign a = wv_q[0];
  assign b = wv_q[1];
  assign c = wv_q[2];
  assign d = wv_q[3];
  assign e = wv_q[4];
  assign f = wv_q[5];
  assign g = wv_q[6];
  assign h = wv_q[7];

  // SHA-256 round datapath on the current working state
  always_comb begin
    s1  = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
    ch  = (e & f) ^ (~e & g);
    s0  = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
    maj = (a & b) ^ (a & c) ^ (b & c);
    t1  = h + s1 + ch + wk_q;
    t2  = s0 + maj;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
      wk_q  <= '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        wv_q[i] <= '0;
      end
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      wk_q  <= wk_d;
      for (int i = 0; i < NUM_WORDS; i++) begin
        wv_q[i] <= wv_d[i];
      end
    end
  end

  // run re-arms from any state; state words are held until the reload
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    wk_d  = wk_q;
    wv_d  = wv_q;
    if (run) begin
      st_d  = ST_ARMED;
      cnt_d = delay0;
    end else begin
      case (st_q)
        ST_ARMED: begin
          if (cnt_q == '0) begin
            wv_d[0] = in0;
            wv_d[1] = in1;
            wv_d[2] = in2;
            wv_d[3] = in3;
            wv_d[4] = in4;
            wv_d[5] = in5;
            wv_d[6] = in6;
            wv_d[7] = in7;
            st_d    = ST_FILL;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_FILL: begin
          wk_d = in8 + in9;
          st_d = ST_ROUND;
        end
        ST_ROUND: begin
          wk_d    = in8 + in9;
          wv_d[0] = t1 + t2;
          wv_d[1] = a;
          wv_d[2] = b;
          wv_d[3] = c;
          wv_d[4] = d + t1;
          wv_d[5] = e;
          wv_d[6] = f;
          wv_d[7] = g;
        end
        default: ;
      endcase
    end
  end

  assign out0 = wv_q[0];
  assign out1 = wv_q[1];
  assign out2 = wv_q[2];
  assign out3 = wv_q[3];
  assign out4 = wv_q[4];
  assign out5 = wv_q[5];
  assign out6 = wv_q[6];
  assign out7 = wv_q[7];

endmodule

// File: tb/tb_xunit_f.sv
// Self-checking bench for xunit_f: FIPS vectors plus randomized streams
// against a software SHA-256 round model.
module tb_xunit_f;

  typedef logic [7:0][31:0] st_t;   // index 0 = a ... 7 = h

  logic        clk = 1'b0;
  logic        rst, run;
  logic [31:0] in0, in1, in2, in3, in4, in5, in6, in7, in8, in9;
  logic [7:0]  delay0;
  logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
  st_t         obs;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ktab [16] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174};

  always #5 clk = ~clk;

  xunit_f dut (
    .clk(clk), .rst(rst), .run(run),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .in5(in5), .in6(in6), .in7(in7), .in8(in8), .in9(in9),
    .delay0(delay0),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out4(out4), .out5(out5), .out6(out6), .out7(out7));

  assign obs = {out7, out6, out5, out4, out3, out2, out1, out0};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference SHA-256 round from the FIPS 180-4 formulas
  function automatic st_t model_round(input st_t s, input logic [31:0] w, input logic [31:0] k);
    logic [31:0] t1, t2;
    st_t r;
    t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
              + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
       + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    r[0] = t1 + t2;
    r[1] = s[0];
    r[2] = s[1];
    r[3] = s[2];
    r[4] = s[3] + t1;
    r[5] = s[4];
    r[6] = s[5];
    r[7] = s[6];
    return r;
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int i = 0; i < 8; i++) s[i] = $urandom;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_state(input st_t s);
    {in7, in6, in5, in4, in3, in2, in1, in0} = s;
  endtask

  // Pulse run, hold the initial state through the load edge, then scramble in0..in7
  task automatic start(input st_t s, input logic [7:0] d);
    set_state(s);
    delay0 = d;
    run    = 1'b1;
    tick();
    run    = 1'b0;
    delay0 = 8'($urandom);
    repeat (int'(d) + 1) tick();
    set_state(rand_state());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run = 1'b0;
    set_state(rand_state());
    in8 = $urandom; in9 = $urandom; delay0 = 8'd0;
    repeat (100) tick();
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want 0", obs);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in8 = $urandom; in9 = $urandom;
      tick();
    end
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL idle_no_run: got %h want 0", obs);
    end
  endtask

  task automatic test_fips_abc();
    st_t iv, exp0, exp1;
    iv   = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
            32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
    exp0 = {32'h1f83d9ab, 32'h9b05688c, 32'h510e527f, 32'hfa2a4622,
            32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667, 32'h5d6aebcd};
    exp1 = {32'h9b05688c, 32'h510e527f, 32'hfa2a4622, 32'h78ce7989,
            32'hbb67ae85, 32'h6a09e667, 32'h5d6aebcd, 32'h5a6ad9ad};
    start(iv, 8'd0);
    in8 = 32'h61626380; in9 = 32'h428a2f98;
    tick();
    in8 = 32'h00000000; in9 = 32'h71374491;
    tick();
    n_checks++;
    if (obs !== exp0) begin
      n_fail++;
      $display("FAIL fips_round0: got %h want %h", obs, exp0);
    end
    in8 = $urandom; in9 = $urandom;
    tick();
    n_checks++;
    if (obs !== exp1) begin
      n_fail++;
      $display("FAIL fips_round1: got %h want %h", obs, exp1);
    end
  endtask

  task automatic test_stream(input logic [7:0] d);
    st_t s, expv [16];
    logic [31:0] w [16];
    s = rand_state();
    for (int i = 0; i < 16; i++) begin
      w[i] = $urandom;
      s    = (i == 0) ? s : s;
    end
    expv[0] = model_round(s, w[0], ktab[0]);
    for (int i = 1; i < 16; i++) expv[i] = model_round(expv[i-1], w[i], ktab[i]);
    start(s, d);
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        in8 = w[i]; in9 = ktab[i];
      end else begin
        in8 = $urandom; in9 = $urandom;
      end
      tick();
      if (i >= 1) begin
        n_checks++;
        if (obs !== expv[i-1]) begin
          n_fail++;
          $display("FAIL stream_d%0d_round%0d: got %h want %h", d, i - 1, obs, expv[i-1]);
        end
      end
    end
  endtask

  task automatic test_delay_hold();
    st_t prev, s, exp0;
    logic [31:0] w0;
    prev = obs;
    s    = rand_state();
    w0   = $urandom;
    exp0 = model_round(s, w0, ktab[0]);
    set_state(s);
    delay0 = 8'd3;
    run    = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in8 = $urandom; in9 = $urandom;
      tick();
      n_checks++;
      if (obs !== prev) begin
        n_fail++;
        $display("FAIL delay_hold_cycle%0d: got %h want %h", i, obs, prev);
      end
    end
    tick();
    n_checks++;
    if (obs !== s) begin
      n_fail++;
      $display("FAIL delay_load: got %h want %h", obs, s);
    end
    set_state(rand_state());
    in8 = w0; in9 = ktab[0];
    tick();
    in8 = $urandom; in9 = $urandom;
    tick();
    n_checks++;
    if (obs !== exp0) begin
      n_fail++;
      $display("FAIL delay_round0: got %h want %h", obs, exp0);
    end
  endtask

  task automatic test_rerun();
    st_t s_old, s_new, e;
    logic [31:0] w;
    s_old = rand_state();
    e     = s_old;
    start(s_old, 8'($urandom_range(0, 2)));
    for (int i = 0; i <= 8; i++) begin
      w = $urandom;
      if (i < 8) e = model_round(e, w, ktab[i]);
      in8 = w; in9 = ktab[i];
      tick();
    end
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL rerun_old_round7: got %h want %h", obs, e);
    end
    s_new = rand_state();
    e     = s_new;
    start(s_new, 8'd1);
    for (int i = 0; i <= 16; i++) begin
      w = $urandom;
      in8 = w; in9 = (i < 16) ? ktab[i] : 32'h0;
      tick();
      if (i >= 1) begin
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL rerun_new_round%0d: got %h want %h", i - 1, obs, e);
        end
      end
      if (i < 16) e = model_round(e, w, ktab[i]);
    end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_midstream: got %h want 0", obs);
    end
    repeat (4) begin
      in8 = $urandom; in9 = $urandom;
      tick();
    end
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_no_restart: got %h want 0", obs);
    end
  endtask

  initial begin
    test_reset();
    test_fips_abc();
    test_stream(8'd0);
    test_stream(8'd3);
    test_stream(8'($urandom_range(1, 9)));
    test_delay_hold();
    test_rerun();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
